// File: rtl/csa_accum_resolve_if.sv
// Stream bundle for the carry-save accumulator: beat input and resolved result output.
// out_ovf exists only when CSA_ACC_OVF_EN is defined.
interface csa_accum_resolve_if #(
    parameter int W     = 32,
    parameter int ACC_W = 40
);
    logic             in_valid;
    logic             in_ready;
    logic [2*W-1:0]   in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data;
`ifdef CSA_ACC_OVF_EN
    logic             out_ovf;
`endif

    modport master (
        output in_valid, in_data, in_last, out_ready,
`ifdef CSA_ACC_OVF_EN
        input  out_ovf,
`endif
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
`ifdef CSA_ACC_OVF_EN
        output out_ovf,
`endif
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/csa_accum_resolve.sv
// Carry-save accumulator of {sum,carry} beats with a chunked ripple resolve per packet.
// Optional sticky overflow flag on out_ovf when CSA_ACC_OVF_EN is defined.
module csa_accum_resolve #(
    parameter int W     = 32,
    parameter int ACC_W = 40,
    parameter int CHUNK = 8
) (
    input logic            clk,
    input logic            rst_n,
    csa_accum_resolve_if.slave bus
);
    localparam int NCH = ACC_W / CHUNK;
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, HOLD} state_t;

    state_t           state, state_d;
    logic [ACC_W-1:0] acc_s, acc_s_d;
    logic [ACC_W-1:0] acc_c, acc_c_d;
    logic [ACC_W-1:0] res, res_d;
    logic [IW-1:0]    idx, idx_d;
    logic             cin, cin_d;

    logic [W-1:0]     sum_w, car_w;
    logic [ACC_W-1:0] op_s, op_c;
    logic [ACC_W-1:0] s1, c1, s2, c2;
    logic [ACC_W-2:0] m1, m2;
    logic [CHUNK:0]   slice;
    logic             accept;

    assign {sum_w, car_w} = bus.in_data;
    assign op_s = ACC_W'(sum_w);
    assign op_c = ACC_W'(car_w) << 1;

    // Two 3:2 layers; only bits below ACC_W-1 can feed a kept carry.
    assign s1 = acc_s ^ acc_c ^ op_s;
    assign m1 = (acc_s[ACC_W-2:0] & acc_c[ACC_W-2:0])
              | (acc_s[ACC_W-2:0] & op_s[ACC_W-2:0])
              | (acc_c[ACC_W-2:0] & op_s[ACC_W-2:0]);
    assign c1 = {m1, 1'b0};
    assign s2 = s1 ^ c1 ^ op_c;
    assign m2 = (s1[ACC_W-2:0] & c1[ACC_W-2:0])
              | (s1[ACC_W-2:0] & op_c[ACC_W-2:0])
              | (c1[ACC_W-2:0] & op_c[ACC_W-2:0]);
    assign c2 = {m2, 1'b0};

    assign slice = {1'b0, acc_s[idx*CHUNK +: CHUNK]}
                 + {1'b0, acc_c[idx*CHUNK +: CHUNK]}
                 + (CHUNK+1)'(cin);

    assign bus.in_ready  = (state == IDLE) || (state == ACCUM);
    assign bus.out_valid = (state == HOLD);
    assign bus.out_data  = res;
    assign accept        = bus.in_valid && bus.in_ready;

`ifdef CSA_ACC_OVF_EN
    logic ovf, ovf_d;
    logic lost;
    // Carries leaving bit ACC_W-1 in either layer.
    assign lost = (acc_s[ACC_W-1] & acc_c[ACC_W-1])
                | (acc_s[ACC_W-1] & op_s[ACC_W-1])
                | (acc_c[ACC_W-1] & op_s[ACC_W-1])
                | (s1[ACC_W-1] & c1[ACC_W-1])
                | (s1[ACC_W-1] & op_c[ACC_W-1])
                | (c1[ACC_W-1] & op_c[ACC_W-1]);
    assign bus.out_ovf = ovf;
`endif

    always_comb begin
        state_d = state;
        acc_s_d = acc_s;
        acc_c_d = acc_c;
        res_d   = res;
        idx_d   = idx;
        cin_d   = cin;
`ifdef CSA_ACC_OVF_EN
        ovf_d   = ovf;
`endif
        unique case (state)
            IDLE, ACCUM: begin
                if (accept) begin
                    acc_s_d = s2;
                    acc_c_d = c2;
`ifdef CSA_ACC_OVF_EN
                    ovf_d   = ovf | lost;
`endif
                    if (bus.in_last) begin
                        state_d = RESOLVE;
                        idx_d   = '0;
                        cin_d   = 1'b0;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            RESOLVE: begin
                res_d[idx*CHUNK +: CHUNK] = slice[CHUNK-1:0];
                cin_d = slice[CHUNK];
                idx_d = idx + 1'b1;
                if (idx == IW'(NCH - 1)) begin
                    state_d = HOLD;
`ifdef CSA_ACC_OVF_EN
                    ovf_d   = ovf | slice[CHUNK];
`endif
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                    acc_s_d = '0;
                    acc_c_d = '0;
`ifdef CSA_ACC_OVF_EN
                    ovf_d   = 1'b0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc_s <= '0;
            acc_c <= '0;
            res   <= '0;
            idx   <= '0;
            cin   <= 1'b0;
`ifdef CSA_ACC_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            state <= state_d;
            acc_s <= acc_s_d;
            acc_c <= acc_c_d;
            res   <= res_d;
            idx   <= idx_d;
            cin   <= cin_d;
`ifdef CSA_ACC_OVF_EN
            ovf   <= ovf_d;
`endif
        end
    end
endmodule
